// File: rtl/sparcool_pkg.sv
//------------------------------------------------------------------------------
// sparcool_pkg
//   Shared widths, instruction field positions and field-extract helpers.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sparcool_pkg;

    localparam int BITNESS = 32;
    localparam int INSTR_W = BITNESS;
    localparam int PC_W    = 32;
    localparam int REG_W   = 5;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    function automatic logic [REG_W-1:0] field_rs(input logic [BITNESS-1:0] instr);
        return instr[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [REG_W-1:0] field_rt(input logic [BITNESS-1:0] instr);
        return instr[RT_MSB:RT_LSB];
    endfunction

    function automatic logic [REG_W-1:0] field_rd(input logic [BITNESS-1:0] instr);
        return instr[RD_MSB:RD_LSB];
    endfunction

endpackage

`default_nettype wire

// File: rtl/issue_dep_check.sv
//------------------------------------------------------------------------------
// issue_dep_check
//   Flags a RAW hazard between the two oldest queue entries (slot 1 reads slot 0's rd).
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module issue_dep_check
    import sparcool_pkg::*;
(
    input  logic [BITNESS-1:0] slot0_instr_i,
    input  logic [BITNESS-1:0] slot1_instr_i,
    output logic               dep_hit_o
);

    logic [REG_W-1:0] rd0;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rt1;
    logic             unused_fields;

    assign rd0 = field_rd(slot0_instr_i);
    assign rs1 = field_rs(slot1_instr_i);
    assign rt1 = field_rt(slot1_instr_i);

    // Register zero is hardwired, so writing it never creates a dependency.
    assign dep_hit_o = (rd0 != REG_ZERO) && ((rs1 == rd0) || (rt1 == rd0));

    assign unused_fields = ^{slot0_instr_i[BITNESS-1:RD_MSB+1], slot0_instr_i[RD_LSB-1:0],
                             slot1_instr_i[BITNESS-1:RS_MSB+1], slot1_instr_i[RT_LSB-1:0]};

endmodule

`default_nettype wire

// File: rtl/instr_issue_queue.sv
//------------------------------------------------------------------------------
// instr_issue_queue
//   In-order fetch-to-core buffer, 1 push / up to 2 in-order issues per cycle, flushable.
//   Optional macro ISSUE_DEP_CHECK_EN holds back slot 1 when it depends on slot 0.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_issue_queue
    import sparcool_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int INSTR_W = sparcool_pkg::INSTR_W,
    parameter int PC_W    = sparcool_pkg::PC_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INSTR_W-1:0]         in_instr,
    input  logic [PC_W-1:0]            in_pc,
    output logic [1:0]                 out_valid,
    input  logic [1:0]                 out_ready,
    output logic [INSTR_W-1:0]         out0_instr,
    output logic [PC_W-1:0]            out0_pc,
    output logic [INSTR_W-1:0]         out1_instr,
    output logic [PC_W-1:0]            out1_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [PC_W-1:0]    pc_mem_q    [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic [PTR_W-1:0] rd_ptr_p1;
    logic             push;
    logic             pop0;
    logic             pop1;
    logic             dep_hit;

    assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);

    // Ready depends only on registered occupancy: no credit for a same-cycle pop.
    assign in_ready = (count_q != CNT_W'(DEPTH));
    assign push     = in_valid & in_ready;

    assign out0_instr = instr_mem_q[rd_ptr_q];
    assign out0_pc    = pc_mem_q[rd_ptr_q];
    assign out1_instr = instr_mem_q[rd_ptr_p1];
    assign out1_pc    = pc_mem_q[rd_ptr_p1];

`ifdef ISSUE_DEP_CHECK_EN
    issue_dep_check u_dep_check (
        .slot0_instr_i (out0_instr),
        .slot1_instr_i (out1_instr),
        .dep_hit_o     (dep_hit)
    );
`else
    assign dep_hit = 1'b0;
`endif

    assign out_valid[0] = (count_q >= CNT_W'(1));
    assign out_valid[1] = (count_q >= CNT_W'(2)) & ~dep_hit;

    // Slot 1 may only issue alongside slot 0 to keep program order.
    assign pop0 = out_valid[0] & out_ready[0];
    assign pop1 = pop0 & out_valid[1] & out_ready[1];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop0) + PTR_W'(pop1);
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop0) - CNT_W'(pop1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally not reset; out_valid gates stale contents.
    always_ff @(posedge clock) begin
        if (push && !flush && !reset) begin
            instr_mem_q[wr_ptr_q] <= in_instr;
            pc_mem_q[wr_ptr_q]    <= in_pc;
        end
    end

    assign count = count_q;

endmodule

`default_nettype wire
